// File: rtl/i2c_host_if_pkg.sv
// i2c_if_pkg: register map, CTR/ISR bit indices and FIFO count-width helper
// shared by the host interface, its FIFOs and the testbench.
package i2c_if_pkg;
  // register addresses
  localparam int ADR_RR   = 8'h00;
  localparam int ADR_PRER = 8'h02;
  localparam int ADR_CTR  = 8'h04;
  localparam int ADR_SR   = 8'h08;
  localparam int ADR_TO   = 8'h0A;
  localparam int ADR_ADDR = 8'h0C;
  localparam int ADR_DR   = 8'h0E;
  localparam int ADR_ISR  = 8'h10;
  localparam int ADR_IER  = 8'h12;
  localparam int ADR_FSR  = 8'h14;
  localparam int ADR_THR  = 8'h16;

  // CTR bit indices (same map as the previous interface)
  localparam int CTR_CORE_EN   = 7;
  localparam int CTR_INTER_EN  = 6;
  localparam int CTR_MODE      = 5;
  localparam int CTR_MASTER_RW = 4;
  localparam int CTR_ACK       = 3;
  localparam int CTR_REP_START = 2;
  localparam int CTR_INTER_RST = 1;
  localparam int CTR_HALT      = 0;

  // ISR bit indices; [5:0] sticky, [7:6] live FIFO levels
  localparam int ISR_INTER  = 0;
  localparam int ISR_ARB    = 1;
  localparam int ISR_TO     = 2;
  localparam int ISR_TXOVF  = 3;
  localparam int ISR_RXOVF  = 4;
  localparam int ISR_RXUNF  = 5;
  localparam int ISR_TXLVL  = 6;
  localparam int ISR_RXLVL  = 7;

  // count must hold 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/i2c_host_if_if.sv
// i2c_host_if_if: host strobe bus (address/data, as/ds/rw, dtack, irq).
interface i2c_host_if_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic [AW-1:0] add_bus;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          as;
  logic          ds;
  logic          rw;
  logic          dtack;
  logic          irq;

  modport master (output add_bus, data_in, as, ds, rw, input data_out, dtack, irq);
  modport slave  (input add_bus, data_in, as, ds, rw, output data_out, dtack, irq);
endinterface

// File: rtl/i2c_host_if_fifo.sv
// i2c_if_fifo: synchronous first-word fall-through byte FIFO. A push into a
// full FIFO is still accepted when a pop happens in the same cycle.
module i2c_if_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          rej
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][7:0] mem;
  logic [PW-1:0]         wp, rp;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rej     = push & ~do_push;
  assign dout    = mem[rp];

  // storage, pointers (wrap modulo DEPTH) and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + PW'(1);
      end
      if (do_pop) rp <= rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/i2c_host_if.sv
// i2c_host_if: host strobe bus to I2C core register interface with TX/RX
// FIFOs, sticky W1C interrupt status and synchronised as/ds strobes.
// Optional macro I2C_IF_FIFO_THR_EN adds the THR register and ISR[7:6] levels.
module i2c_host_if import i2c_if_pkg::*; #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  i2c_host_if_if.slave hif,
  input  logic       time_rst,
  input  logic       bus_busy, byte_trans, slave_addressed, arb_lost,
  input  logic       slave_rw, time_out, ack_rec, inter,
  output logic       core_en, inter_en, mode, master_rw, ack, rep_start, inter_rst, halt,
  output logic [7:0] prescale, time_out_reg, slave_add,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);
  localparam int CW = cnt_w(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] as_sync, ds_sync;
  logic                   as_d, ds_d, as_rise, as_fall, ds_rise;
  logic [AW-1:0]          addr_q;
  logic                   addr_vld, dtack_pend, acc, wr, rd;
  logic [7:0]             d8, rd_val, ctr, ier, dr_q, sr_q, thr, isr_all;
  logic [5:0]             isr, isr_set, isr_clr;
  logic [1:0]             lvl;
  logic                   int_q, arb_q, to_q;
  logic [CW-1:0]          tx_cnt, rx_cnt;
  logic [7:0]             rx_dout;
  logic                   tx_full, tx_empty, tx_rej, rx_full, rx_empty, rx_rej;
  logic                   sel_rr, sel_dr, sel_isr;

  assign as_rise = as_sync[SYNC_STAGES-1] & ~as_d;
  assign as_fall = ~as_sync[SYNC_STAGES-1] & as_d;
  assign ds_rise = ds_sync[SYNC_STAGES-1] & ~ds_d;
  assign acc     = ds_rise & addr_vld & ~time_rst;
  assign wr      = acc & hif.rw;
  assign rd      = acc & ~hif.rw;
  assign d8      = hif.data_in[7:0];
  assign sel_rr  = (addr_q == AW'(ADR_RR));
  assign sel_dr  = (addr_q == AW'(ADR_DR));
  assign sel_isr = (addr_q == AW'(ADR_ISR));

  assign {core_en, inter_en, mode, master_rw, ack, rep_start, inter_rst, halt} = ctr;
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  i2c_if_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_tx (
    .clk(clk), .rst(rst), .clr(time_rst), .push(wr & sel_dr), .din(d8),
    .pop(tx_ready), .dout(tx_data), .count(tx_cnt), .full(tx_full),
    .empty(tx_empty), .rej(tx_rej));

  i2c_if_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_rx (
    .clk(clk), .rst(rst), .clr(time_rst), .push(rx_valid), .din(rx_data),
    .pop(rd & sel_rr), .dout(rx_dout), .count(rx_cnt), .full(rx_full),
    .empty(rx_empty), .rej(rx_rej));

`ifdef I2C_IF_FIFO_THR_EN
  assign lvl = {(thr[7:4] != 4'd0) && (4'(rx_cnt) >= thr[7:4]),
                (4'(tx_cnt) <= thr[3:0])};
`else
  assign lvl = 2'b00;
`endif

  assign isr_all = {lvl, isr};
  assign isr_set = {rd & sel_rr & rx_empty, rx_rej, tx_rej,
                    time_out & ~to_q, arb_lost & ~arb_q, inter & ~int_q};
  assign isr_clr = (wr & sel_isr) ? d8[5:0] : 6'd0;

  // register read mux; unmapped addresses read 0
  always_comb begin
    rd_val = 8'h00;
    case (addr_q)
      AW'(ADR_RR):   rd_val = rx_empty ? 8'h00 : rx_dout;
      AW'(ADR_PRER): rd_val = prescale;
      AW'(ADR_CTR):  rd_val = ctr;
      AW'(ADR_SR):   rd_val = sr_q;
      AW'(ADR_TO):   rd_val = time_out_reg;
      AW'(ADR_ADDR): rd_val = slave_add;
      AW'(ADR_DR):   rd_val = dr_q;
      AW'(ADR_ISR):  rd_val = isr_all;
      AW'(ADR_IER):  rd_val = ier;
      AW'(ADR_FSR):  rd_val = {4'(rx_cnt), 4'(tx_cnt)};
`ifdef I2C_IF_FIFO_THR_EN
      AW'(ADR_THR):  rd_val = thr;
`endif
      default:       rd_val = 8'h00;
    endcase
  end

  // strobe synchronisers, status sampling and core-status edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      as_sync <= '0;
      ds_sync <= '0;
      as_d    <= 1'b0;
      ds_d    <= 1'b0;
      sr_q    <= '0;
      int_q   <= 1'b0;
      arb_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      as_sync <= {as_sync[SYNC_STAGES-2:0], hif.as};
      ds_sync <= {ds_sync[SYNC_STAGES-2:0], hif.ds};
      as_d    <= as_sync[SYNC_STAGES-1];
      ds_d    <= ds_sync[SYNC_STAGES-1];
      sr_q    <= {byte_trans, slave_addressed, bus_busy, arb_lost,
                  time_out, slave_rw, inter, ack_rec};
      int_q   <= inter;
      arb_q   <= arb_lost;
      to_q    <= time_out;
    end
  end

  // configuration registers survive time_rst
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale     <= '0;
      time_out_reg <= '0;
      slave_add    <= '0;
      ier          <= '0;
      dr_q         <= '0;
      thr          <= '0;
    end else if (wr) begin
      if (addr_q == AW'(ADR_PRER)) prescale     <= d8;
      if (addr_q == AW'(ADR_TO))   time_out_reg <= d8;
      if (addr_q == AW'(ADR_ADDR)) slave_add    <= {d8[7:1], 1'b0};
      if (addr_q == AW'(ADR_IER))  ier          <= d8;
      if (sel_dr)                  dr_q         <= d8;
`ifdef I2C_IF_FIFO_THR_EN
      if (addr_q == AW'(ADR_THR))  thr          <= d8;
`endif
    end
  end

  // access sequencing, CTR and sticky ISR; time_rst aborts and clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      addr_vld     <= 1'b0;
      dtack_pend   <= 1'b0;
      hif.dtack    <= 1'b0;
      hif.data_out <= '0;
      ctr          <= '0;
      isr          <= '0;
    end else if (time_rst) begin
      addr_vld     <= 1'b0;
      dtack_pend   <= 1'b0;
      hif.dtack    <= 1'b0;
      ctr          <= '0;
      isr          <= '0;
    end else begin
      if (as_rise) begin
        addr_q   <= hif.add_bus;
        addr_vld <= 1'b1;
      end else if (as_fall) begin
        addr_vld <= 1'b0;
      end
      dtack_pend <= acc;
      hif.dtack  <= dtack_pend;
      if (rd) hif.data_out <= DW'(rd_val);
      if (bus_busy & ~byte_trans) ctr[CTR_INTER_RST:CTR_HALT] <= 2'b00;
      if (wr && addr_q == AW'(ADR_CTR)) ctr <= d8;
      isr <= (isr & ~isr_clr) | isr_set;
    end
  end

  // interrupt follows the ISR register by one cycle
  always_ff @(posedge clk) begin
    if (rst) hif.irq <= 1'b0;
    else     hif.irq <= inter_en & |(isr_all & ier);
  end
endmodule

// File: tb/tb_i2c_host_if.sv
// tb_i2c_host_if: directed checks of the I2C host register interface
// (default build, FIFO_DEPTH=4, SYNC_STAGES=2).
module tb_i2c_host_if;
  import i2c_if_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_host_if_if #(.AW(8), .DW(8)) bus ();

  logic time_rst = 0, bus_busy = 0, byte_trans = 0, slave_addressed = 0;
  logic arb_lost = 0, slave_rw = 0, time_out = 0, ack_rec = 0, inter = 0;
  logic core_en, inter_en, mode, master_rw, ack, rep_start, inter_rst, halt;
  logic [7:0] prescale, time_out_reg, slave_add, tx_data;
  logic       tx_valid, rx_ready;
  logic       tx_ready = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;

  i2c_host_if #(.AW(8), .DW(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .hif(bus), .time_rst(time_rst),
    .bus_busy(bus_busy), .byte_trans(byte_trans), .slave_addressed(slave_addressed),
    .arb_lost(arb_lost), .slave_rw(slave_rw), .time_out(time_out),
    .ack_rec(ack_rec), .inter(inter),
    .core_en(core_en), .inter_en(inter_en), .mode(mode), .master_rw(master_rw),
    .ack(ack), .rep_start(rep_start), .inter_rst(inter_rst), .halt(halt),
    .prescale(prescale), .time_out_reg(time_out_reg), .slave_add(slave_add),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready));

  int n_chk = 0, n_pass = 0;
  int arb_at = 0;
  int last_lat;
  logic dtack_next;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ctr_o();
    return {core_en, inter_en, mode, master_rw, ack, rep_start, inter_rst, halt};
  endfunction

  // one host access: as first, ds three cycles later, wait bounded for dtack
  task automatic host_acc(input logic w, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] q);
    int lat;
    @(negedge clk);
    bus.add_bus = a; bus.data_in = d; bus.rw = w; bus.as = 1'b1;
    repeat (3) @(negedge clk);
    bus.ds = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == arb_at) arb_lost = 1'b1;
      @(posedge clk); #1;
      if (bus.dtack) begin lat = k; break; end
    end
    chk("dtack_seen", (lat > 0), 1);
    q = bus.data_out;
    last_lat = lat;
    @(posedge clk); #1;
    dtack_next = bus.dtack;
    @(negedge clk);
    bus.as = 1'b0; bus.ds = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] q;
    host_acc(1'b1, a, d, q);
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [7:0] q);
    host_acc(1'b0, a, 8'h00, q);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] q;
    logic [7:0] txv [4];
    int dt_seen;
    bus.add_bus = 0; bus.data_in = 0; bus.as = 0; bus.ds = 0; bus.rw = 0;
    txv[0] = 8'hA1; txv[1] = 8'hA2; txv[2] = 8'hA3; txv[3] = 8'hA4;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_data_out", bus.data_out, 8'h00);
    chk("rst_dtack", bus.dtack, 0);
    chk("rst_irq", bus.irq, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_ctr", ctr_o(), 8'h00);

    // PRER write/read, dtack latency SYNC_STAGES+2 and width
    reg_wr(8'h02, 8'h5A);
    chk("prer_wr_lat", last_lat, 4);
    chk("prescale", prescale, 8'h5A);
    reg_rd(8'h02, q);
    chk("prer_rd", q, 8'h5A);
    chk("prer_rd_lat", last_lat, 4);
    chk("dtack_width", dtack_next, 0);

    // unmapped read gives 0 but still acks; ADDR drops bit 0; TO
    reg_rd(8'h20, q);
    chk("unmapped_rd", q, 8'h00);
    reg_wr(8'h0C, 8'h5B);
    chk("slave_add", slave_add, 8'h5A);
    reg_wr(8'h0A, 8'h33);
    chk("time_out_reg", time_out_reg, 8'h33);

    // TX overflow: 5 writes into depth 4
    for (int i = 0; i < 4; i++) reg_wr(8'h0E, txv[i]);
    reg_wr(8'h0E, 8'hA5);
    reg_rd(8'h14, q);
    chk("fsr_tx_full", q, 8'h04);
    reg_rd(8'h10, q);
    chk("isr_tx_ovf", q, 8'h08);
    reg_rd(8'h0E, q);
    chk("dr_last", q, 8'hA5);
    chk("tx_valid_full", tx_valid, 1);
    @(negedge clk); tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_pop_data", tx_data, txv[i]);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("tx_valid_empty", tx_valid, 0);
    reg_wr(8'h10, 8'hFF);
    reg_rd(8'h10, q);
    chk("isr_cleared", q, 8'h00);

    // RX pushes, reads, underflow interrupt
    @(negedge clk); rx_data = 8'h11; rx_valid = 1'b1;
    @(negedge clk); rx_data = 8'h22;
    @(negedge clk); rx_valid = 1'b0;
    reg_rd(8'h14, q);
    chk("fsr_rx2", q, 8'h20);
    reg_rd(8'h00, q);
    chk("rr_first", q, 8'h11);
    reg_rd(8'h00, q);
    chk("rr_second", q, 8'h22);
    reg_wr(8'h12, 8'h20);
    reg_wr(8'h04, 8'h40);
    chk("irq_before_unf", bus.irq, 0);
    reg_rd(8'h00, q);
    chk("rr_empty", q, 8'h00);
    chk("irq_rx_unf", bus.irq, 1);
    reg_rd(8'h10, q);
    chk("isr_rx_unf", q, 8'h20);
    reg_wr(8'h10, 8'h20);
    chk("irq_after_w1c", bus.irq, 0);

    // CTR[1:0] auto-clear when busy without byte transfer
    @(negedge clk); bus_busy = 1'b1; byte_trans = 1'b1;
    reg_wr(8'h04, 8'hA3);
    chk("ctr_hold", ctr_o(), 8'hA3);
    @(negedge clk); byte_trans = 1'b0;
    @(posedge clk); #1;
    chk("ctr_autoclr", ctr_o(), 8'hA0);
    @(negedge clk); bus_busy = 1'b0;

    // arb_lost rise coincides with W1C of ISR[1]: set wins
    reg_wr(8'h12, 8'h02);
    reg_wr(8'h04, 8'h40);
    arb_at = 3;
    reg_wr(8'h10, 8'h02);
    arb_at = 0;
    reg_rd(8'h10, q);
    chk("isr_arb_set_wins", q, 8'h02);
    chk("irq_arb", bus.irq, 1);
    reg_wr(8'h10, 8'h02);
    reg_rd(8'h10, q);
    chk("isr_arb_cleared", q, 8'h00);
    chk("irq_arb_drop", bus.irq, 0);
    @(negedge clk); arb_lost = 1'b0;

    // time_rst during an in-flight access
    reg_wr(8'h02, 8'h20);
    reg_wr(8'h0E, 8'h01);
    reg_wr(8'h0E, 8'h02);
    reg_rd(8'h14, q);
    chk("fsr_tx2", q, 8'h02);
    @(negedge clk);
    bus.add_bus = 8'h02; bus.data_in = 8'h77; bus.rw = 1'b1; bus.as = 1'b1;
    repeat (3) @(negedge clk);
    bus.ds = 1'b1; time_rst = 1'b1;
    dt_seen = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.dtack) dt_seen++; end
    @(negedge clk); time_rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (bus.dtack) dt_seen++; end
    chk("trst_no_dtack", dt_seen, 0);
    chk("trst_tx_empty", tx_valid, 0);
    chk("trst_ctr", ctr_o(), 8'h00);
    chk("trst_prer_kept", prescale, 8'h20);
    @(negedge clk); bus.as = 1'b0; bus.ds = 1'b0;
    repeat (5) @(negedge clk);
    reg_rd(8'h14, q);
    chk("trst_fsr", q, 8'h00);
    reg_rd(8'h12, q);
    chk("trst_ier_kept", q, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
